// File: rtl/l1_wt_cache_pkg.sv
// Shared types and width helpers for the direct-mapped write-through L1 cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MISS_RD = 2'd1,
      WR_THRU = 2'd2,
      RESP    = 2'd3
   } state_e;

   function automatic int off_bits(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int tag_bits(input int addr_width, input int data_width, input int index_bits);
      return addr_width - index_bits - off_bits(data_width);
   endfunction

endpackage

// File: rtl/l1_wt_cache_array.sv
// Line storage for l1_wt_cache: valid/tag/data per line, combinational read,
// one write port. Only the valid bits are cleared by reset.
module l1_wt_cache_array #(
   parameter int INDEX_BITS = 4,
   parameter int TAG_W      = 26,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output logic                  o_rd_valid,
   output logic [TAG_W-1:0]      o_rd_tag,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   input  logic                  i_we,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  logic [TAG_W-1:0]      i_wr_tag,
   input  logic [DATA_WIDTH-1:0] i_wr_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]      r_valid;
   logic [TAG_W-1:0]      r_tag  [LINES];
   logic [DATA_WIDTH-1:0] r_data [LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else if (i_we) begin
         r_valid[i_wr_index] <= 1'b1;
      end
   end

   // Tag/data need no reset: they are never observed while the valid bit is low.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_wr_index]  <= i_wr_tag;
         r_data[i_wr_index] <= i_wr_data;
      end
   end

   assign o_rd_valid = r_valid[i_rd_index];
   assign o_rd_tag   = r_tag[i_rd_index];
   assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/l1_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 cache, one word per line.
// Define CACHE_STATS_EN to build the read hit/miss counters; otherwise they read 0.
module l1_wt_cache
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count,
   output state_e                dbg_state
);

   localparam int OFF_BITS = off_bits(DATA_WIDTH);
   localparam int TAG_W    = tag_bits(ADDR_WIDTH, DATA_WIDTH, INDEX_BITS);

   state_e r_state;
   state_e w_next_state;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [INDEX_BITS-1:0] w_cpu_index;
   logic [TAG_W-1:0]      w_cpu_tag;
   logic [INDEX_BITS-1:0] w_lat_index;
   logic [TAG_W-1:0]      w_lat_tag;
   logic                  w_line_valid;
   logic [TAG_W-1:0]      w_line_tag;
   logic [DATA_WIDTH-1:0] w_line_data;
   logic                  w_hit;
   logic                  w_idle_req;
   logic                  w_fill;
   logic                  w_wr_hit;
   logic                  w_arr_we;
   logic [INDEX_BITS-1:0] w_arr_index;
   logic [TAG_W-1:0]      w_arr_tag;
   logic [DATA_WIDTH-1:0] w_arr_data;
   logic                  w_cpu_resp;
   logic                  w_mem_read;
   logic                  w_mem_write;

   assign w_cpu_index = cpu_addr[OFF_BITS +: INDEX_BITS];
   assign w_cpu_tag   = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
   assign w_lat_index = r_addr[OFF_BITS +: INDEX_BITS];
   assign w_lat_tag   = r_addr[ADDR_WIDTH-1 -: TAG_W];
   assign w_hit       = w_line_valid && (w_line_tag == w_cpu_tag);
   assign w_idle_req  = (r_state == IDLE) && (cpu_read || cpu_write);

   // One write port shared by the IDLE write-hit update and the MISS_RD fill.
   assign w_fill      = (r_state == MISS_RD) && mem_resp;
   assign w_wr_hit    = (r_state == IDLE) && cpu_write && w_hit;
   assign w_arr_we    = w_fill || w_wr_hit;
   assign w_arr_index = w_fill ? w_lat_index : w_cpu_index;
   assign w_arr_tag   = w_fill ? w_lat_tag   : w_cpu_tag;
   assign w_arr_data  = w_fill ? mem_rdata   : cpu_wdata;

   l1_wt_cache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_W      (TAG_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_index (w_cpu_index),
      .o_rd_valid (w_line_valid),
      .o_rd_tag   (w_line_tag),
      .o_rd_data  (w_line_data),
      .i_we       (w_arr_we),
      .i_wr_index (w_arr_index),
      .i_wr_tag   (w_arr_tag),
      .i_wr_data  (w_arr_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Simultaneous read and write resolve as a write.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (cpu_write) begin
               w_next_state = WR_THRU;
            end else if (cpu_read) begin
               w_next_state = w_hit ? RESP : MISS_RD;
            end
         end
         MISS_RD: if (mem_resp) w_next_state = RESP;
         WR_THRU: if (mem_resp) w_next_state = RESP;
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Decoded from the state flop, so these behave as registered outputs.
   always_comb begin
      w_cpu_resp  = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      case (r_state)
         MISS_RD: w_mem_read  = 1'b1;
         WR_THRU: w_mem_write = 1'b1;
         RESP:    w_cpu_resp  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_idle_req) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            if (!cpu_write && w_hit) begin
               r_rdata <= w_line_data;
            end
         end
         if (w_fill) begin
            r_rdata <= mem_rdata;
         end
      end
   end

   assign cpu_resp  = w_cpu_resp;
   assign mem_read  = w_mem_read;
   assign mem_write = w_mem_write;
   assign cpu_rdata = r_rdata;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign dbg_state = r_state;

`ifdef CACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if ((r_state == IDLE) && cpu_read && !cpu_write) begin
         if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
         end else begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

   a_no_rw_overlap: assert property (@(posedge clk) disable iff (!rst_n)
      !((r_state == IDLE) && cpu_read && cpu_write));

endmodule

// File: tb/tb_l1_wt_cache.sv
// Scoreboarded bench for l1_wt_cache: directed cache scenarios, a mid-miss reset,
// then random traffic checked against a tag/memory reference model.
module tb_l1_wt_cache;

   localparam int DELAY = 4;

   typedef struct {
      logic        is_read;
      logic [31:0] addr;
      logic [31:0] data;
      int          lat;
      int          ops;
      int          t_issue;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic [1:0]  dbg_state;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];

   // memory behind the DUT and the reference model's own view of memory
   logic [31:0] mem_arr [0:255];
   logic [31:0] m_mem   [0:255];
   logic        m_valid [0:15];
   int          m_tag   [0:15];
   int          m_hits;
   int          m_misses;

   l1_wt_cache dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_read   (cpu_read),
      .cpu_write  (cpu_write),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_resp   (cpu_resp),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp),
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .dbg_state  (dbg_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_stats;
`ifdef CACHE_STATS_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`else
      check("hit_count", hit_count, 32'd0);
      check("miss_count", miss_count, 32'd0);
`endif
   endtask

   // memory model: answers DELAY cycles after a request appears
   initial begin
      int mem_wait;
      mem_wait  = 0;
      mem_resp  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_resp = 1'b0;
         if (!rst_n || !(mem_read || mem_write)) begin
            mem_wait = 0;
         end else begin
            mem_wait++;
            if (mem_wait == DELAY) begin
               mem_wait = 0;
               if (exp_q.size() > 0) begin
                  check("mem_addr", mem_addr, exp_q[0].addr);
                  if (mem_write) check("mem_wdata", mem_wdata, exp_q[0].data);
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_mem_op: addr 0x%08h with no request outstanding", mem_addr);
               end
               if (mem_write) mem_arr[mem_addr[9:2]] = mem_wdata;
               else mem_rdata = mem_arr[mem_addr[9:2]];
               mem_resp = 1'b1;
            end
         end
      end
   end

   // monitor: counts memory transactions and retires one expectation per cpu_resp
   initial begin
      exp_t it;
      int   ops;
      logic prev_mem;
      ops      = 0;
      prev_mem = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ops      = 0;
            prev_mem = 1'b0;
         end else begin
            if (mem_read && mem_write) begin
               checks++;
               errors++;
               $display("FAIL mem_rw_both: mem_read=1 mem_write=1 required not both");
            end
            if ((mem_read || mem_write) && !prev_mem) ops++;
            prev_mem = mem_read || mem_write;
            if (cpu_resp) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: cpu_resp=1 with empty queue");
               end else begin
                  it = exp_q.pop_front();
                  if (it.is_read) check("cpu_rdata", cpu_rdata, it.data);
                  check("latency", cyc - it.t_issue, it.lat);
                  check("mem_ops", ops, it.ops);
                  ops = 0;
               end
            end
         end
      end
   end

   // driver: predicts the outcome from the model, issues the request, holds it until cpu_resp
   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data);
      exp_t it;
      int   idx;
      int   tg;
      bit   hit;
      bit   got;
      idx = int'(addr[5:2]);
      tg  = int'(addr[31:6]);
      hit = m_valid[idx] && (m_tag[idx] == tg);
      it.is_read = !wr;
      it.addr    = addr;
      it.data    = wr ? data : m_mem[addr[9:2]];
      it.lat     = (!wr && hit) ? 1 : DELAY + 1;
      it.ops     = (!wr && hit) ? 0 : 1;
      if (wr) begin
         m_mem[addr[9:2]] = data;
      end else if (hit) begin
         m_hits++;
      end else begin
         m_misses++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
      end
      @(negedge clk);
      it.t_issue = cyc;
      exp_q.push_back(it);
      cpu_read  = !wr;
      cpu_write = wr;
      cpu_addr  = addr;
      cpu_wdata = data;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
         @(negedge clk);
         got = cpu_resp;
      end
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: no cpu_resp for addr 0x%08h within 50 cycles", addr);
         exp_q.delete();
      end
   endtask

   initial begin
      bit got;
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         mem_arr[i] = v;
         m_mem[i]   = v;
      end
      mem_arr[8'h04] = 32'h1111_2222;
      m_mem[8'h04]   = 32'h1111_2222;
      mem_arr[8'h14] = 32'h3333_4444;
      m_mem[8'h14]   = 32'h3333_4444;
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
      end
      m_hits    = 0;
      m_misses  = 0;
      rst_n     = 1'b0;
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;

      repeat (3) @(negedge clk);
      check("rst_cpu_resp", {31'd0, cpu_resp}, 32'd0);
      check("rst_mem_read", {31'd0, mem_read}, 32'd0);
      check("rst_mem_write", {31'd0, mem_write}, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);
      check_stats();
      rst_n = 1'b1;

      // cold miss, hit, write-through, hit on updated line, same-index conflict
      do_req(1'b0, 32'h10, $urandom);       check_stats();
      do_req(1'b0, 32'h10, $urandom);       check_stats();
      do_req(1'b1, 32'h10, 32'hDEAD_BEEF);  check_stats();
      do_req(1'b0, 32'h10, $urandom);       check_stats();
      do_req(1'b0, 32'h50, $urandom);       check_stats();
      do_req(1'b0, 32'h10, $urandom);       check_stats();
      do_req(1'b0, 32'h13, $urandom);       check_stats();

      // reset while a miss is outstanding
      @(negedge clk);
      cpu_read = 1'b1;
      cpu_addr = 32'h50;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         got = mem_read;
      end
      check("miss_rd_entered", {31'd0, got}, 32'd1);
      #2;
      rst_n    = 1'b0;
      cpu_read = 1'b0;
      #1;
      check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
      check("midrst_cpu_resp", {31'd0, cpu_resp}, 32'd0);
      check("midrst_hit_count", hit_count, 32'd0);
      check("midrst_miss_count", miss_count, 32'd0);
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_req(1'b0, 32'h50, $urandom);       check_stats();
      do_req(1'b0, 32'h50, $urandom);       check_stats();

      // random traffic over 64 words (4 tags per index), random byte offsets
      for (int t = 0; t < 150; t++) begin
         do_req($urandom_range(0, 99) < 30,
                (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
                $urandom);
         check_stats();
      end

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
